// File: rtl/serial_word_collector_pkg.sv
// serial_word_collector_pkg: bit-order constants and output-buffer state shared across the collector.
package serial_word_collector_pkg;
  localparam logic DIR_MSB_FIRST = 1'b1;
  localparam logic DIR_LSB_FIRST = 1'b0;
  typedef enum logic {ST_EMPTY, ST_FULL} buf_state_e;
endpackage

// File: rtl/serial_word_collector_bit_counter.sv
// serial_word_collector_bit_counter: modulo-WIDTH bit counter; o_wrap marks the bit that completes a word.
module serial_word_collector_bit_counter #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_wrap
);
  logic [CNT_W-1:0] r_cnt;
  assign o_wrap = i_en && !i_clr && (r_cnt == CNT_W'(WIDTH - 1));
  assign o_cnt  = r_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cnt <= '0;
    else if (i_clr || o_wrap) r_cnt <= '0;
    else if (i_en) r_cnt <= r_cnt + 1'b1;
  end
endmodule

// File: rtl/serial_word_collector.sv
// serial_word_collector: reassembles serial bits into WIDTH-bit words behind a one-word VALID/READY buffer.
module serial_word_collector
  import serial_word_collector_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     RESET_N,
  input  logic                     ENB,
  input  logic                     DIR,
  input  logic                     S_IN,
  input  logic                     CLR,
  input  logic                     READY,
  output logic [WIDTH-1:0]         Q,
  output logic                     VALID,
  output logic                     OVF,
  output logic [$clog2(WIDTH)-1:0] BIT_CNT
);
  localparam int CNT_W = $clog2(WIDTH);
  logic [WIDTH-1:0] r_acc, r_q, w_word;
  buf_state_e r_state, w_state_nxt;
  logic r_ovf, w_done, w_load, w_set_ovf;
  assign w_word = (DIR == DIR_MSB_FIRST) ? {r_acc[WIDTH-2:0], S_IN} : {S_IN, r_acc[WIDTH-1:1]};
  serial_word_collector_bit_counter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst_n (RESET_N),
    .i_en  (ENB),
    .i_clr (CLR),
    .o_cnt (BIT_CNT),
    .o_wrap(w_done)
  );
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) r_state <= ST_EMPTY;
    else r_state <= w_state_nxt;
  end
  // A word completing while the consumer drains the buffer replaces it; otherwise a full buffer drops it.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_set_ovf   = 1'b0;
    if (CLR) w_state_nxt = ST_EMPTY;
    else if (r_state == ST_EMPTY) begin
      w_state_nxt = w_done ? ST_FULL : ST_EMPTY;
      w_load      = w_done;
    end else begin
      w_state_nxt = (READY && !w_done) ? ST_EMPTY : ST_FULL;
      w_load      = READY && w_done;
      w_set_ovf   = !READY && w_done;
    end
  end
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      r_acc <= '0;
      r_q   <= '0;
      r_ovf <= 1'b0;
    end else if (CLR) begin
      r_acc <= '0;
      r_q   <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (ENB) r_acc <= w_word;
      if (w_load) r_q <= w_word;
      if (w_set_ovf) r_ovf <= 1'b1;
    end
  end
  assign Q     = r_q;
  assign VALID = (r_state == ST_FULL);
  assign OVF   = r_ovf;
endmodule

// File: tb/tb_serial_word_collector.sv
// tb_serial_word_collector: directed vector table, reset corner case, and randomized run against a word-level model.
module tb_serial_word_collector;
  logic clk = 0, rst_n = 0, enb = 0, dir = 1, s_in = 0, clr = 0, ready = 0;
  logic [3:0] q;
  logic valid, ovf;
  logic [1:0] cnt;
  int checks = 0, errors = 0;

  serial_word_collector #(.WIDTH(4)) dut (
    .clk(clk), .RESET_N(rst_n), .ENB(enb), .DIR(dir), .S_IN(s_in), .CLR(clr),
    .READY(ready), .Q(q), .VALID(valid), .OVF(ovf), .BIT_CNT(cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic enb, dir, s, clr, rdy;
    logic [3:0] q;
    logic v, o;
    logic [1:0] c;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic e, d, s, cl, r, input logic [3:0] eq, input logic ev, eo, input logic [1:0] ec);
    vec_t t;
    t.enb = e; t.dir = d; t.s = s; t.clr = cl; t.rdy = r; t.q = eq; t.v = ev; t.o = eo; t.c = ec;
    tbl.push_back(t);
  endtask

  task automatic check(input string name, input logic [3:0] eq, input logic ev, eo, input logic [1:0] ec);
    checks++;
    if ({q, valid, ovf, cnt} !== {eq, ev, eo, ec}) begin
      errors++;
      $display("FAIL %s: got Q=%b VALID=%b OVF=%b BIT_CNT=%0d, expected Q=%b VALID=%b OVF=%b BIT_CNT=%0d",
               name, q, valid, ovf, cnt, eq, ev, eo, ec);
    end
  endtask

  task automatic step(input logic e, d, s, cl, r);
    enb = e; dir = d; s_in = s; clr = cl; ready = r;
    @(posedge clk);
    #1;
  endtask

  logic       m_bits[4];
  int         m_cnt;
  logic [3:0] m_q, m_word;
  logic       m_valid, m_ovf, m_done;

  initial begin
    // Reset pulsed mid-word clears everything immediately, then collection restarts at bit 0.
    #2 rst_n = 1;
    step(1, 1, 1, 0, 0);
    step(1, 1, 1, 0, 0);
    check("pre_reset_cnt", 4'b0000, 0, 0, 2'd2);
    #2 rst_n = 0;
    #1 check("async_reset", 4'b0000, 0, 0, 2'd0);
    @(negedge clk) rst_n = 1;
    step(1, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0);
    check("post_reset_word", 4'b0101, 1, 0, 2'd0);
    step(0, 1, 0, 0, 1);
    check("post_reset_drain", 4'b0101, 0, 0, 2'd0);

    // MSB-first word, held until READY
    add(1,1,1,0,0, 4'b0101,0,0,1); add(1,1,0,0,0, 4'b0101,0,0,2);
    add(1,1,1,0,0, 4'b0101,0,0,3); add(1,1,1,0,0, 4'b1011,1,0,0);
    add(0,1,0,0,0, 4'b1011,1,0,0); add(0,1,0,0,1, 4'b1011,0,0,0);
    // LSB-first word with ENB gaps
    add(1,0,1,0,0, 4'b1011,0,0,1); add(0,0,1,0,0, 4'b1011,0,0,1);
    add(1,0,0,0,0, 4'b1011,0,0,2); add(0,0,0,0,0, 4'b1011,0,0,2);
    add(1,0,1,0,0, 4'b1011,0,0,3); add(1,0,1,0,0, 4'b1101,1,0,0);
    // Overflow on stalled consumer, then CLR
    add(0,1,0,0,1, 4'b1101,0,0,0);
    add(1,1,1,0,0, 4'b1101,0,0,1); add(1,1,0,0,0, 4'b1101,0,0,2);
    add(1,1,1,0,0, 4'b1101,0,0,3); add(1,1,1,0,0, 4'b1011,1,0,0);
    add(1,1,0,0,0, 4'b1011,1,0,1); add(1,1,1,0,0, 4'b1011,1,0,2);
    add(1,1,1,0,0, 4'b1011,1,0,3); add(1,1,0,0,0, 4'b1011,1,1,0);
    add(1,1,1,1,1, 4'b0000,0,0,0);
    // READY on the completing edge replaces the word without overflow
    add(1,1,1,0,0, 4'b0000,0,0,1); add(1,1,0,0,0, 4'b0000,0,0,2);
    add(1,1,1,0,0, 4'b0000,0,0,3); add(1,1,1,0,0, 4'b1011,1,0,0);
    add(1,1,0,0,0, 4'b1011,1,0,1); add(1,1,1,0,0, 4'b1011,1,0,2);
    add(1,1,1,0,0, 4'b1011,1,0,3); add(1,1,0,0,1, 4'b0110,1,0,0);
    // CLR mid-word discards the partial word and the presented bit
    add(0,1,0,0,1, 4'b0110,0,0,0);
    add(1,1,1,0,0, 4'b0110,0,0,1); add(1,1,1,0,0, 4'b0110,0,0,2);
    add(1,1,1,1,0, 4'b0000,0,0,0);
    add(1,1,0,0,0, 4'b0000,0,0,1); add(1,1,0,0,0, 4'b0000,0,0,2);
    add(1,1,1,0,0, 4'b0000,0,0,3); add(1,1,1,0,0, 4'b0011,1,0,0);
    foreach (tbl[i]) begin
      step(tbl[i].enb, tbl[i].dir, tbl[i].s, tbl[i].clr, tbl[i].rdy);
      check($sformatf("vec%0d", i), tbl[i].q, tbl[i].v, tbl[i].o, tbl[i].c);
    end

    // Randomized run against a word-level model: bits are kept in arrival order and placed by DIR on completion.
    step(0, 1, 0, 1, 0);
    m_cnt = 0; m_q = 0; m_valid = 0; m_ovf = 0;
    for (int n = 0; n < 2000; n++) begin
      logic e, d, s, cl, r;
      e  = ($urandom_range(0, 3) != 0);
      d  = (m_cnt == 0) ? 1'($urandom_range(0, 1)) : dir;
      s  = 1'($urandom_range(0, 1));
      cl = ($urandom_range(0, 40) == 0);
      r  = ($urandom_range(0, 2) == 0);
      m_done = 0;
      if (cl) begin
        m_cnt = 0; m_q = 0; m_valid = 0; m_ovf = 0;
      end else begin
        if (e) begin
          m_bits[m_cnt] = s;
          if (m_cnt == 3) begin
            m_done = 1;
            for (int k = 0; k < 4; k++) m_word[d ? 3 - k : k] = m_bits[k];
          end
          m_cnt = (m_cnt + 1) % 4;
        end
        if (!m_valid) begin
          if (m_done) begin m_q = m_word; m_valid = 1; end
        end else if (r) begin
          if (m_done) m_q = m_word;
          else m_valid = 0;
        end else if (m_done) m_ovf = 1;
      end
      step(e, d, s, cl, r);
      check($sformatf("rand%0d", n), m_q, m_valid, m_ovf, 2'(m_cnt));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_word_collector.md
Name: serial_word_collector

Overview:
- Downstream stage of the 4-bit shift register: consumes its serial output S_OUT on each enabled shift cycle and reassembles WIDTH-bit words.
- Presents each assembled word on a registered parallel output with a VALID/READY handshake.
- One-word output buffer; a sticky overflow flag reports words dropped by a stalled consumer.

Parameters:
- WIDTH, 4, bits per assembled word; must be >= 2.
- CNT_W, $clog2(WIDTH), width of the bit counter; derived as a localparam, not overridable.

Ports:
- clk  input  1  system clock, rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- ENB  input  1  bit strobe: S_IN is sampled on rising clk while ENB=1; tie to the upstream shift enable.
- DIR  input  1  bit order: 1 = first bit received ends in Q[WIDTH-1] (MSB first); 0 = first bit ends in Q[0] (LSB first).
- S_IN  input  1  serial data, driven from upstream S_OUT.
- CLR  input  1  synchronous clear of the collector.
- READY  input  1  consumer accepts Q this cycle when VALID=1.
- Q  output  WIDTH  last completed word, registered.
- VALID  output  1  Q holds an unconsumed word.
- OVF  output  1  sticky: a completed word was dropped.
- BIT_CNT  output  CNT_W  bits collected in the current partial word.

Behaviour:
- Reset (RESET_N=0, asynchronous):
  - Q=0, VALID=0, OVF=0, BIT_CNT=0, accumulator=0.
  - All outputs are registered.
- Accumulator update on an edge with ENB=1 and CLR=0:
  - DIR=1: acc <= {acc[WIDTH-2:0], S_IN}.
  - DIR=0: acc <= {S_IN, acc[WIDTH-1:1]}.
  - DIR is sampled per bit; a DIR change mid-word is not guarded. Callers hold DIR stable for a whole word.
- Counter:
  - BIT_CNT increments on each accepted bit.
  - On the bit taken when BIT_CNT=WIDTH-1, the word completes and BIT_CNT wraps to 0.
  - The completed word is the shifted accumulator value including that bit.
- Output buffer FSM, states EMPTY (VALID=0) and FULL (VALID=1):
  - EMPTY + completion -> FULL; Q <= word.
  - FULL + READY, no completion -> EMPTY; Q holds its last value.
  - FULL + READY + completion on the same edge -> stays FULL; Q <= new word; no overflow.
  - FULL + !READY + completion -> stays FULL; Q unchanged; new word dropped; OVF <= 1.
  - EMPTY + READY: no effect.
- Latency: VALID rises on the same edge that samples the WIDTH-th bit, so Q/VALID are visible one cycle after that bit is presented.
- ENB=0: accumulator and BIT_CNT hold; the handshake still operates.
- CLR=1 (synchronous, priority over ENB and READY):
  - acc=0, BIT_CNT=0, Q=0, VALID=0, OVF=0.
  - The bit presented in that cycle is discarded.
- OVF clears only on reset or CLR.
- Reset asserted mid-word or mid-handshake: the partial word and the pending word are both lost; collection restarts at bit 0 after release.

Decomposition:
- Shared package:
  - DIR_MSB_FIRST=1'b1 and DIR_LSB_FIRST=1'b0 constants, shared with the shift-register stage.
  - Output-buffer state enum {ST_EMPTY, ST_FULL}.
- One natural sub-module: bit_counter (modulo-WIDTH counter with enable, sync clear, and a wrap pulse used as the completion strobe).
- The accumulator and output buffer stay in the top module.

Test Plan (WIDTH=4):
1. Stream bits with ENB=1, then pulse RESET_N=0 after 2 bits -> immediately Q=0000, VALID=0, OVF=0, BIT_CNT=0; a later 4-bit word assembles correctly from bit 0.
2. DIR=1, READY=0, S_IN=1,0,1,1 on 4 enabled edges -> after the 4th edge Q=1011, VALID=1, BIT_CNT=0; Q stays 1011 until a READY cycle, after which VALID=0 and Q=1011.
3. DIR=0, S_IN=1,0,1,1 -> Q=1101, VALID=1; ENB=0 gaps between bits change neither BIT_CNT nor the result.
4. READY=0, DIR=1, 8 bits 1011 then 0110 -> Q=1011 throughout, OVF=1 after the 8th edge, VALID=1; CLR=1 then gives Q=0000, VALID=0, OVF=0.
5. VALID=1 with Q=1011; assert READY on the edge completing 0110 -> Q=0110, VALID stays 1, OVF=0.
6. Two bits collected (BIT_CNT=2), then CLR=1 with ENB=1 -> BIT_CNT=0; the next 4 bits 0,0,1,1 (DIR=1) give Q=0011.
